// File: rtl/vga_sched_pkg.sv
// rtl/vga_sched_pkg.sv - shared types and defaults for the frame-buffer port scheduler
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } schedState_t;

  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_BURST       = 8;

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// rtl/vga_fb_scheduler_if.sv - burst command port between scheduler and frame-buffer controller
interface vga_fb_scheduler_if #(
  parameter int ADDR_W = 22
);
  logic              oCmdValid;
  logic              oCmdWe;
  logic [ADDR_W-1:0] oCmdAddr;
  logic              iCmdReady;
  logic              iBurstDone;

  modport master (
    output oCmdValid, oCmdWe, oCmdAddr,
    input  iCmdReady, iBurstDone
  );

  modport slave (
    input  oCmdValid, oCmdWe, oCmdAddr,
    output iCmdReady, iBurstDone
  );
endinterface

// File: rtl/vga_rd_addr_gen.sv
// rtl/vga_rd_addr_gen.sv - display read address counter with end-of-frame detect
module vga_rd_addr_gen
  import vga_sched_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BURST       = DEF_BURST,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFrameSync,
  input  logic              iRdAccept,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oRdDone
);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);

  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] addrNext;
  logic              rdDone;

  assign addrNext = rdAddr + STEP;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdAddr <= '0;
      rdDone <= 1'b0;
    end else if (iFrameSync) begin
      rdAddr <= '0;
      rdDone <= 1'b0;
    end else if (iRdAccept) begin
      rdAddr <= addrNext;
      if (addrNext == FRAME_END) begin
        rdDone <= 1'b1;
      end
    end
  end

  // A frame sync seen in IDLE already steers the decision to the new frame start.
  assign oRdAddr = iFrameSync ? '0 : rdAddr;
  assign oRdDone = iFrameSync ? 1'b0 : rdDone;

endmodule

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - arbitrates display reads and Sobel write-back bursts on one command port
module vga_fb_scheduler
  import vga_sched_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BURST       = DEF_BURST,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int LVL_W       = 10,
  parameter int FIFO_DEPTH  = 512,
  parameter int LOW_WM      = 64
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFrameSync,
  input  logic [LVL_W-1:0]  iRdLevel,
  input  logic              iRdActive,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  output logic              oWrGnt,
  output logic              oWrDone,
  output logic              oUnderrun,
  vga_fb_scheduler_if.master cmd
);

  localparam logic [LVL_W:0] RD_ROOM = (LVL_W + 1)'(FIFO_DEPTH - BURST);
  localparam logic [LVL_W:0] LOW_LVL = (LVL_W + 1)'(LOW_WM);

  schedState_t       state;
  schedState_t       stateNext;
  logic              cmdWe;
  logic [ADDR_W-1:0] cmdAddr;
  logic              lastGnt;
  logic              wrGnt;
  logic              wrDone;
  logic              underrun;

  logic [ADDR_W-1:0] rdAddr;
  logic              rdDone;
  logic              rdOk;
  logic              rdUrgent;
  logic              selRd;
  logic              selWr;
  logic              rdAccept;
  logic              wrAccept;
  logic              burstEnd;

  vga_rd_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST       (BURST),
    .FRAME_WORDS (FRAME_WORDS)
  ) uRdAddr (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iFrameSync (iFrameSync),
    .iRdAccept  (rdAccept),
    .oRdAddr    (rdAddr),
    .oRdDone    (rdDone)
  );

  assign rdOk     = !rdDone && ({1'b0, iRdLevel} <= RD_ROOM);
  assign rdUrgent = rdOk && ({1'b0, iRdLevel} < LOW_LVL);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    selRd     = 1'b0;
    selWr     = 1'b0;
    rdAccept  = 1'b0;
    wrAccept  = 1'b0;
    burstEnd  = 1'b0;
    case (state)
      IDLE: begin
        // Writes alternate with non-urgent reads; an urgent read always wins.
        if (rdUrgent) begin
          selRd = 1'b1;
        end else if (iWrReq && (lastGnt == GNT_RD || !rdOk)) begin
          selWr = 1'b1;
        end else if (rdOk) begin
          selRd = 1'b1;
        end
        if (selRd || selWr) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd.iCmdReady) begin
          stateNext = WAIT;
          rdAccept  = !cmdWe;
          wrAccept  = cmdWe;
        end
      end
      WAIT: begin
        if (cmd.iBurstDone) begin
          stateNext = IDLE;
          burstEnd  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cmdWe    <= 1'b0;
      cmdAddr  <= '0;
      lastGnt  <= GNT_WR;
      wrGnt    <= 1'b0;
      wrDone   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (selRd) begin
        cmdWe   <= 1'b0;
        cmdAddr <= rdAddr;
      end else if (selWr) begin
        cmdWe   <= 1'b1;
        cmdAddr <= iWrAddr;
      end
      if (rdAccept || wrAccept) begin
        lastGnt <= cmdWe ? GNT_WR : GNT_RD;
      end
      wrGnt  <= wrAccept;
      wrDone <= burstEnd && cmdWe;
      if (iRdActive && iRdLevel == '0) begin
        underrun <= 1'b1;
      end else if (iFrameSync) begin
        underrun <= 1'b0;
      end
    end
  end

  assign cmd.oCmdValid = (state == ISSUE);
  assign cmd.oCmdWe    = cmdWe;
  assign cmd.oCmdAddr  = cmdAddr;
  assign oWrGnt        = wrGnt;
  assign oWrDone       = wrDone;
  assign oUnderrun     = underrun;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - self-checking bench for vga_fb_scheduler
module tb_vga_fb_scheduler;
  import vga_sched_pkg::*;

  localparam int AW    = 22;
  localparam int BST   = 8;
  localparam int FRAME = 4096;
  localparam int LW    = 10;
  localparam int DEPTH = 512;
  localparam int LOWWM = 64;

  typedef struct {
    int lvl;
    bit wr;
    int wa;
    bit eV;
    bit eWe;
    int eA;
  } vec_t;

  logic          iCLK       = 1'b0;
  logic          iRST_N     = 1'b0;
  logic          iFrameSync = 1'b0;
  logic [LW-1:0] iRdLevel   = '0;
  logic          iRdActive  = 1'b0;
  logic          iWrReq     = 1'b0;
  logic [AW-1:0] iWrAddr    = '0;
  logic          oWrGnt;
  logic          oWrDone;
  logic          oUnderrun;

  vga_fb_scheduler_if #(.ADDR_W(AW)) cmdBus ();

  vga_fb_scheduler #(
    .ADDR_W      (AW),
    .BURST       (BST),
    .FRAME_WORDS (FRAME),
    .LVL_W       (LW),
    .FIFO_DEPTH  (DEPTH),
    .LOW_WM      (LOWWM)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iFrameSync (iFrameSync),
    .iRdLevel   (iRdLevel),
    .iRdActive  (iRdActive),
    .iWrReq     (iWrReq),
    .iWrAddr    (iWrAddr),
    .oWrGnt     (oWrGnt),
    .oWrDone    (oWrDone),
    .oUnderrun  (oUnderrun),
    .cmd        (cmdBus)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int mReads = 0;
  bit mLastRd = 1'b0;
  int bnd [6] = '{0, 63, 64, 504, 505, 511};
  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic vec_t mk(int l, bit w, int wa, bit v, bit we, int a);
    vec_t r;
    r.lvl = l; r.wr = w; r.wa = wa; r.eV = v; r.eWe = we; r.eA = a;
    return r;
  endfunction

  // Reference arbitration: what the next command should be, from the scheduling rules.
  task automatic predict(input int lvl, input bit wr, input int wa,
                         output bit v, output bit we, output int a);
    bit frameDone;
    bit rdOk;
    frameDone = (mReads * BST >= FRAME);
    rdOk      = !frameDone && (lvl <= DEPTH - BST);
    v = 1'b1; we = 1'b0; a = mReads * BST;
    if (rdOk && lvl < LOWWM) begin
      we = 1'b0;
    end else if (wr && (mLastRd || !rdOk)) begin
      we = 1'b1; a = wa;
    end else if (!rdOk) begin
      v = 1'b0; a = 0;
    end
  endtask

  task automatic account(input bit we);
    if (!we) mReads++;
    mLastRd = !we;
  endtask

  task automatic decide(input string name, input int lvl, input bit wr, input int wa,
                        input bit eV, input bit eWe, input int eA);
    iRdLevel = LW'(lvl);
    iWrReq   = wr;
    iWrAddr  = AW'(wa);
    tick();
    chk({name, " valid"}, int'(cmdBus.oCmdValid), int'(eV));
    if (eV) begin
      chk({name, " we"}, int'(cmdBus.oCmdWe), int'(eWe));
      chk({name, " addr"}, int'(cmdBus.oCmdAddr), eA);
    end
  endtask

  task automatic finishBurst(input string name, input bit isWr, input int eA,
                             input int rdyDly, input int doneDly);
    for (int i = 0; i < rdyDly; i++) begin
      cmdBus.iCmdReady  = 1'b0;
      cmdBus.iBurstDone = 1'($urandom % 2);
      tick();
      chk({name, " hold valid"}, int'(cmdBus.oCmdValid), 1);
      chk({name, " hold addr"}, int'(cmdBus.oCmdAddr), eA);
      chk({name, " hold we"}, int'(cmdBus.oCmdWe), int'(isWr));
    end
    cmdBus.iCmdReady  = 1'b1;
    cmdBus.iBurstDone = 1'b0;
    tick();
    cmdBus.iCmdReady = 1'b0;
    iWrReq = 1'b0;
    chk({name, " accept valid"}, int'(cmdBus.oCmdValid), 0);
    chk({name, " wrGnt"}, int'(oWrGnt), int'(isWr));
    chk({name, " early wrDone"}, int'(oWrDone), 0);
    for (int i = 0; i < doneDly; i++) begin
      cmdBus.iCmdReady = 1'($urandom % 2);
      tick();
      chk({name, " wait valid"}, int'(cmdBus.oCmdValid), 0);
      chk({name, " wrGnt pulse"}, int'(oWrGnt), 0);
    end
    cmdBus.iCmdReady  = 1'b0;
    cmdBus.iBurstDone = 1'b1;
    tick();
    cmdBus.iBurstDone = 1'b0;
    chk({name, " wrDone"}, int'(oWrDone), int'(isWr));
    chk({name, " idle valid"}, int'(cmdBus.oCmdValid), 0);
  endtask

  initial begin
    bit v;
    bit we;
    int a;
    int lvl;
    bit wr;
    int wa;

    vecs[0]  = mk(0,   0, 0,       1, 0, 0);
    vecs[1]  = mk(0,   0, 0,       1, 0, 8);
    vecs[2]  = mk(0,   0, 0,       1, 0, 16);
    vecs[3]  = mk(100, 1, 'h1000,  1, 1, 'h1000);
    vecs[4]  = mk(100, 1, 'h1000,  1, 0, 24);
    vecs[5]  = mk(100, 1, 'h1000,  1, 1, 'h1000);
    vecs[6]  = mk(100, 1, 'h1000,  1, 0, 32);
    vecs[7]  = mk(30,  1, 'h2000,  1, 0, 40);
    vecs[8]  = mk(30,  1, 'h2000,  1, 0, 48);
    vecs[9]  = mk(64,  1, 'h2000,  1, 1, 'h2000);
    vecs[10] = mk(505, 0, 0,       0, 0, 0);
    vecs[11] = mk(505, 1, 'h3000,  1, 1, 'h3000);
    vecs[12] = mk(505, 0, 0,       0, 0, 0);
    vecs[13] = mk(504, 0, 0,       1, 0, 56);
    vecs[14] = mk(63,  1, 'h4000,  1, 0, 64);
    vecs[15] = mk(511, 1, 'h4008,  1, 1, 'h4008);

    cmdBus.iCmdReady  = 1'b0;
    cmdBus.iBurstDone = 1'b0;
    tick();
    tick();
    chk("rst valid", int'(cmdBus.oCmdValid), 0);
    chk("rst we", int'(cmdBus.oCmdWe), 0);
    chk("rst addr", int'(cmdBus.oCmdAddr), 0);
    chk("rst wrGnt", int'(oWrGnt), 0);
    chk("rst wrDone", int'(oWrDone), 0);
    chk("rst underrun", int'(oUnderrun), 0);
    iRST_N = 1'b1;
    chk("release valid", int'(cmdBus.oCmdValid), 0);

    for (int i = 0; i < 16; i++) begin
      decide($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].wr, vecs[i].wa,
             vecs[i].eV, vecs[i].eWe, vecs[i].eA);
      if (vecs[i].eV) begin
        finishBurst($sformatf("vec%0d", i), vecs[i].eWe, vecs[i].eA, i % 3, i % 2);
        account(vecs[i].eWe);
      end
    end

    decide("hold", 0, 0, 0, 1, 0, 72);
    finishBurst("hold", 0, 72, 5, 2);
    account(1'b0);

    for (int n = 0; n < 200; n++) begin
      lvl = (($urandom % 4) == 0) ? bnd[$urandom % 6] : int'($urandom_range(0, 511));
      wr  = 1'($urandom % 2);
      wa  = int'($urandom_range(0, 'h7FFFF)) << 3;
      predict(lvl, wr, wa, v, we, a);
      decide($sformatf("rnd%0d", n), lvl, wr, wa, v, we, a);
      if (v) begin
        finishBurst($sformatf("rnd%0d", n), we, a, int'($urandom % 4), int'($urandom % 4));
        account(we);
      end
    end

    while (mReads * BST < FRAME) begin
      decide("frame rd", 0, 0, 0, 1, 0, mReads * BST);
      finishBurst("frame rd", 0, mReads * BST, 0, 0);
      account(1'b0);
    end
    decide("frame done 1", 0, 0, 0, 0, 0, 0);
    decide("frame done 2", 300, 0, 0, 0, 0, 0);

    decide("end write", 0, 1, 'h5000, 1, 1, 'h5000);
    cmdBus.iCmdReady = 1'b1;
    tick();
    cmdBus.iCmdReady = 1'b0;
    iWrReq = 1'b0;
    chk("end write gnt", int'(oWrGnt), 1);
    iFrameSync = 1'b1;
    tick();
    iFrameSync = 1'b0;
    chk("sync in wait valid", int'(cmdBus.oCmdValid), 0);
    chk("sync in wait wrDone", int'(oWrDone), 0);
    cmdBus.iBurstDone = 1'b1;
    tick();
    cmdBus.iBurstDone = 1'b0;
    chk("sync in wait done", int'(oWrDone), 1);
    mReads = 0;
    mLastRd = 1'b0;

    decide("restart rd", 0, 0, 0, 1, 0, 0);
    cmdBus.iCmdReady = 1'b1;
    iFrameSync = 1'b1;
    tick();
    cmdBus.iCmdReady = 1'b0;
    iFrameSync = 1'b0;
    chk("sync accept valid", int'(cmdBus.oCmdValid), 0);
    cmdBus.iBurstDone = 1'b1;
    tick();
    cmdBus.iBurstDone = 1'b0;
    mLastRd = 1'b1;
    decide("sync beats accept", 0, 0, 0, 1, 0, 0);
    finishBurst("sync beats accept", 0, 0, 1, 1);
    account(1'b0);
    decide("after restart", 0, 0, 0, 1, 0, 8);
    finishBurst("after restart", 0, 8, 0, 0);
    account(1'b0);

    chk("underrun idle", int'(oUnderrun), 0);
    iRdActive = 1'b1;
    iRdLevel  = '0;
    tick();
    iRdActive = 1'b0;
    iRdLevel  = LW'(200);
    chk("underrun set", int'(oUnderrun), 1);
    tick();
    tick();
    tick();
    chk("underrun sticky", int'(oUnderrun), 1);
    iFrameSync = 1'b1;
    tick();
    iFrameSync = 1'b0;
    chk("underrun clear", int'(oUnderrun), 0);
    iRdActive  = 1'b1;
    iRdLevel   = '0;
    iFrameSync = 1'b1;
    tick();
    iRdActive  = 1'b0;
    iFrameSync = 1'b0;
    iRdLevel   = LW'(200);
    chk("underrun set beats sync", int'(oUnderrun), 1);

    chk("pre reset valid", int'(cmdBus.oCmdValid), 1);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("async rst valid", int'(cmdBus.oCmdValid), 0);
    chk("async rst addr", int'(cmdBus.oCmdAddr), 0);
    chk("async rst underrun", int'(oUnderrun), 0);
    tick();
    iRST_N = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Frame-buffer port scheduler between the VGA display path and the Sobel result writer. Owns the single burst command port to the frame-buffer memory controller and generates the display read addresses. Keeps the VGA line FIFO ahead of the pixel request stream and grants the remaining bandwidth to Sobel write-back bursts, with one burst outstanding at a time. Sits between the VGA pixel FIFO / Sobel engine and the memory controller.

## Interface
- ADDR_W, 22: word address width; matches the VGA pixel address width.
- BURST, 8: words per memory command, power of two.
- FRAME_WORDS, 307200: display words per frame (640x480).
- LVL_W, 10: width of the FIFO level input.
- FIFO_DEPTH, 512: VGA line FIFO depth in words.
- LOW_WM, 64: level below which a read is urgent.

- iCLK  in  1  clock (VGA pixel clock domain).
- iRST_N  in  1  reset; asynchronous, active-low.
- iFrameSync  in  1  one-cycle pulse at vertical sync; restarts the display frame.
- iRdLevel  in  LVL_W  current VGA line FIFO fill level in words.
- iRdActive  in  1  display is consuming pixels (active video).
- iWrReq  in  1  Sobel has a write burst pending; level, held until oWrGnt.
- iWrAddr  in  ADDR_W  write burst base address; stable while iWrReq is high.
- oCmdValid  out  1  memory command valid.
- oCmdWe  out  1  1 = write burst, 0 = read burst.
- oCmdAddr  out  ADDR_W  burst base address.
- iCmdReady  in  1  memory controller accepts the command when high with oCmdValid.
- iBurstDone  in  1  one-cycle pulse when the outstanding burst finishes.
- oWrGnt  out  1  one-cycle pulse when a write command is accepted.
- oWrDone  out  1  one-cycle pulse when a write burst completes.
- oUnderrun  out  1  sticky; FIFO was empty during active video this frame.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: evaluate every cycle; priority order:
  1. Urgent read: rd_ok and iRdLevel < LOW_WM.
  2. Write: iWrReq and last grant was read, or no read eligible.
  3. Read: rd_ok.
  - rd_ok = !rd_done and iRdLevel <= FIFO_DEPTH-BURST.
  - On selection, latch oCmdWe/oCmdAddr and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: oCmdValid=1, fields held stable. On iCmdReady go to WAIT.
  - Read accepted: rd_addr += BURST.
  - Write accepted: pulse oWrGnt.
  - Record the granted type as last grant.
- WAIT: oCmdValid=0. On iBurstDone return to IDLE; pulse oWrDone if it was a write.
- Read address: rd_addr starts at 0.
  - When rd_addr+BURST reaches FRAME_WORDS, set rd_done; no further reads until iFrameSync.
  - FRAME_WORDS must be a multiple of BURST.
- iFrameSync: in the same cycle, rd_addr<=0, rd_done<=0, oUnderrun<=0.
  - Does not abort ISSUE or WAIT; the in-flight burst completes normally.
  - If iFrameSync coincides with read acceptance, iFrameSync wins: rd_addr=0, not BURST.
- oUnderrun sets when iRdActive and iRdLevel==0. If this coincides with iFrameSync, the set wins.
- Address arithmetic is unsigned ADDR_W bits; no wrap inside a frame.

## Timing
- Reset values: state IDLE, oCmdValid=0, oCmdWe=0, oCmdAddr=0, oWrGnt=0, oWrDone=0, oUnderrun=0, rd_addr=0, rd_done=0, last grant=write (so the first contest goes to read).
- Decision latency: condition true in IDLE at cycle N gives oCmdValid=1 at N+1.
- Command hold: oCmdValid stays high until iCmdReady, with no field change.
- Back-to-back: iBurstDone at N gives IDLE at N+1 and the next oCmdValid at N+2. Minimum 2 idle cycles between commands.
- oWrGnt is in the cycle after acceptance. oWrDone is in the cycle after iBurstDone.
- iBurstDone outside WAIT is ignored. iCmdReady outside ISSUE is ignored.
- Asynchronous reset mid-burst returns to IDLE immediately. The memory controller is reset by the same iRST_N.

## Structure
- Package vga_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - grant-type constants GNT_RD/GNT_WR;
  - default FRAME_WORDS and BURST.
- Sub-module vga_rd_addr_gen holds rd_addr, rd_done, frame restart and the end-of-frame compare. It is instantiated once.
- Arbitration, FSM and the underrun flag stay in the top level.

## Test plan
- Reset, then iRdLevel=0, iCmdReady=1 -> first command at cycle 2 after reset release, read at addr 0. Repeat with iBurstDone: addrs 0,8,16,…
- iRdLevel=100, iWrReq=1 with iWrAddr=0x1000 -> grants alternate read, write, read. oWrGnt pulses once per write; iWrAddr=0x1000 appears on oCmdAddr.
- iRdLevel=30 (urgent) with iWrReq=1 -> reads only, until the level is raised to 64. Then a write is granted next.
- iRdLevel=505 (>FIFO_DEPTH-BURST) with iWrReq=0 -> no command issued. Lowering the level to 504 -> read issued.
- Run reads to the frame end -> last read addr 307192, rd_done set, no more reads. iFrameSync during WAIT -> burst completes, next read at addr 0.
- iRdActive=1, iRdLevel=0 for one cycle -> oUnderrun=1 and held. iFrameSync -> cleared. iCmdReady held low for 5 cycles -> oCmdValid and oCmdAddr stable throughout.
